// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU register block in front of the uart bit-level core.
// Holds a TX FIFO that feeds the core's tx_valid/tx_data/tx_complete handshake
// and an RX FIFO that captures received bytes. Exposes DATA, STATUS and
// CONTROL registers with a one-cycle registered response.
// Optional feature macro: UART_CTRL_IRQ_EN (implements CONTROL and a level irq).
module uart_ctrl #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_complete,
    input  logic        uart_rx_complete,
    input  logic [7:0]  uart_rx_data,
    output logic        irq
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_CW = RX_AW + 1;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    // FIFO storage (no reset: pointers and counts define validity)
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];

    logic [TX_AW-1:0] tx_rd_reg, tx_rd_next, tx_wr_reg, tx_wr_next;
    logic [TX_CW-1:0] tx_count_reg, tx_count_next;
    logic [RX_AW-1:0] rx_rd_reg, rx_rd_next, rx_wr_reg, rx_wr_next;
    logic [RX_CW-1:0] rx_count_reg, rx_count_next;
    logic             overflow_reg, overflow_next;
    logic             in_flight_reg;
    logic [31:0]      rdata_next;
    logic [1:0]       control_value;

    // Bus decode
    logic rd_any, rd_data, wr_data, wr_status;
    assign rd_any    = cpu_req & ~cpu_write;
    assign rd_data   = rd_any & (cpu_addr == ADDR_DATA);
    assign wr_data   = cpu_req & cpu_write & (cpu_addr == ADDR_DATA);
    assign wr_status = cpu_req & cpu_write & (cpu_addr == ADDR_STATUS);

    // FIFO flags and accepted push/pop events
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop, overflow_set;
    assign tx_empty = (tx_count_reg == '0);
    assign tx_full  = (tx_count_reg == TX_CW'(TX_DEPTH));
    assign rx_empty = (rx_count_reg == '0);
    assign rx_full  = (rx_count_reg == RX_CW'(RX_DEPTH));

    // A pop in the same cycle always makes room, so a full FIFO still accepts
    assign tx_pop       = uart_tx_complete & ~tx_empty;
    assign tx_push      = wr_data & (~tx_full | tx_pop);
    assign rx_pop       = rd_data & ~rx_empty;
    assign rx_push      = uart_rx_complete & (~rx_full | rx_pop);
    assign overflow_set = uart_rx_complete & rx_full & ~rx_pop;

    // Core-facing head of the TX FIFO, held until the core reports completion
    assign uart_tx_valid = ~tx_empty;
    assign uart_tx_data  = tx_mem[tx_rd_reg];

    // STATUS fields
    logic [TX_CW-1:0] tx_free;
    logic             tx_idle;
    logic [31:0]      status_value;
    assign tx_free      = TX_CW'(TX_DEPTH) - tx_count_reg;
    assign tx_idle      = tx_empty & ~in_flight_reg;
    assign status_value = {14'h0, tx_idle, overflow_reg, 8'(rx_count_reg), 8'(tx_free)};

    // Next-state computation for both FIFOs and the overflow flag
    always_comb begin
        tx_rd_next    = tx_rd_reg;
        tx_wr_next    = tx_wr_reg;
        tx_count_next = tx_count_reg;
        rx_rd_next    = rx_rd_reg;
        rx_wr_next    = rx_wr_reg;
        rx_count_next = rx_count_reg;
        overflow_next = overflow_reg;
        if (tx_pop)  tx_rd_next = tx_rd_reg + 1'b1;
        if (tx_push) tx_wr_next = tx_wr_reg + 1'b1;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count_reg + 1'b1;
            2'b01:   tx_count_next = tx_count_reg - 1'b1;
            default: tx_count_next = tx_count_reg;
        endcase
        if (rx_pop)  rx_rd_next = rx_rd_reg + 1'b1;
        if (rx_push) rx_wr_next = rx_wr_reg + 1'b1;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_next = rx_count_reg + 1'b1;
            2'b01:   rx_count_next = rx_count_reg - 1'b1;
            default: rx_count_next = rx_count_reg;
        endcase
        // A new overflow beats a simultaneous software clear
        if (wr_status && cpu_wdata[16]) overflow_next = 1'b0;
        if (overflow_set)               overflow_next = 1'b1;
    end

    // Read-data mux, sampled into cpu_rdata on the request edge
    always_comb begin
        rdata_next = '0;
        case (cpu_addr)
            ADDR_DATA:    rdata_next = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rd_reg]};
            ADDR_STATUS:  rdata_next = status_value;
            ADDR_CONTROL: rdata_next = {30'h0, control_value};
            default:      rdata_next = '0;
        endcase
    end

    // FIFO storage writes
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr_reg] <= cpu_wdata[7:0];
        if (rx_push) rx_mem[rx_wr_reg] <= uart_rx_data;
    end

    // Pointers, counts, flags and the registered bus response
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_rd_reg     <= '0;
            tx_wr_reg     <= '0;
            tx_count_reg  <= '0;
            rx_rd_reg     <= '0;
            rx_wr_reg     <= '0;
            rx_count_reg  <= '0;
            overflow_reg  <= 1'b0;
            in_flight_reg <= 1'b0;
            cpu_ack       <= 1'b0;
            cpu_rdata     <= '0;
        end else begin
            tx_rd_reg    <= tx_rd_next;
            tx_wr_reg    <= tx_wr_next;
            tx_count_reg <= tx_count_next;
            rx_rd_reg    <= rx_rd_next;
            rx_wr_reg    <= rx_wr_next;
            rx_count_reg <= rx_count_next;
            overflow_reg <= overflow_next;
            // In flight once the core sees a valid head; completion ends the frame
            if (uart_tx_complete)   in_flight_reg <= 1'b0;
            else if (uart_tx_valid) in_flight_reg <= 1'b1;
            cpu_ack <= cpu_req;
            if (rd_any) cpu_rdata <= rdata_next;
        end
    end

`ifdef UART_CTRL_IRQ_EN
    logic       wr_control;
    logic [1:0] control_reg;
    logic       irq_reg;
    assign wr_control    = cpu_req & cpu_write & (cpu_addr == ADDR_CONTROL);
    assign control_value = control_reg;
    assign irq           = irq_reg;

    // Interrupt enables and the registered level interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            control_reg <= 2'b00;
            irq_reg     <= 1'b0;
        end else begin
            if (wr_control) control_reg <= cpu_wdata[1:0];
            irq_reg <= (control_reg[0] & ~rx_empty) |
                       (control_reg[1] & tx_empty)  |
                       (control_reg[0] & overflow_reg);
        end
    end
`else
    assign control_value = 2'b00;
    assign irq           = 1'b0;
`endif

    // Most write-data bits have no destination
    logic unused_wdata;
    assign unused_wdata = ^cpu_wdata;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed and randomized checks of uart_ctrl against a queue-based
// model of the register map and FIFO rules.
module tb_uart_ctrl;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_write;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_complete, uart_rx_complete;
    logic [7:0]  uart_rx_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned tx_q[$];
    byte unsigned rx_q[$];
    bit           ovf_m;
    logic [1:0]   ctrl_m;

    logic [31:0] exp_rd, got_rd;
    logic        got_ack;

    always #5 clock = ~clock;

    uart_ctrl #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
        .uart_tx_complete(uart_tx_complete), .uart_rx_complete(uart_rx_complete),
        .uart_rx_data(uart_rx_data), .irq(irq)
    );

    function automatic logic [31:0] status_model();
        logic [31:0] s;
        s        = '0;
        s[7:0]   = 8'(DEPTH - tx_q.size());
        s[15:8]  = 8'(rx_q.size());
        s[16]    = ovf_m;
        s[17]    = (tx_q.size() == 0);
        return s;
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        ovf_m  = 1'b0;
        ctrl_m = 2'b00;
    endtask

    // One clock of stimulus: predicts the response from the pre-edge model,
    // applies the FIFO rules to the model, drives the DUT and captures outputs.
    task automatic step(input logic req, input logic wr, input logic [1:0] addr,
                        input logic [31:0] wd, input logic txc, input logic rxc,
                        input logic [7:0] rxd);
        bit ovf_set;
        exp_rd = '0;
        if (req && !wr) begin
            case (addr)
                2'd0:    exp_rd = (rx_q.size() != 0) ? {24'h0, rx_q[0]} : 32'hFFFF_FFFF;
                2'd1:    exp_rd = status_model();
                2'd2:    exp_rd = {30'h0, ctrl_m};
                default: exp_rd = '0;
            endcase
        end
        ovf_set = 1'b0;
        if (req && !wr && addr == 2'd0 && rx_q.size() != 0) void'(rx_q.pop_front());
        if (rxc) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(rxd);
            else ovf_set = 1'b1;
        end
        if (req && wr && addr == 2'd1 && wd[16]) ovf_m = 1'b0;
        if (ovf_set) ovf_m = 1'b1;
        if (txc && tx_q.size() != 0) void'(tx_q.pop_front());
        if (req && wr && addr == 2'd0 && tx_q.size() < DEPTH) tx_q.push_back(wd[7:0]);
`ifdef UART_CTRL_IRQ_EN
        if (req && wr && addr == 2'd2) ctrl_m = wd[1:0];
`endif
        cpu_req          = req;
        cpu_write        = wr;
        cpu_addr         = addr;
        cpu_wdata        = wd;
        uart_tx_complete = txc;
        uart_rx_complete = rxc;
        uart_rx_data     = rxd;
        @(negedge clock);
        got_ack          = cpu_ack;
        got_rd           = cpu_rdata;
        cpu_req          = 1'b0;
        cpu_write        = 1'b0;
        uart_tx_complete = 1'b0;
        uart_rx_complete = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] addr, input logic [31:0] data);
        step(1'b1, 1'b1, addr, data, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rd_reg(input logic [1:0] addr);
        step(1'b1, 1'b0, addr, 32'h0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b want 0", cpu_ack); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %08h want 00000000", cpu_rdata); end
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0b want 0", uart_tx_valid); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", irq); end
        reset = 1'b0;
        model_reset();
        rd_reg(2'd1);
        checks++; if (got_ack !== 1'b1) begin errors++; $display("FAIL reset_status_ack got %0b want 1", got_ack); end
        checks++; if (got_rd !== 32'h0002_0010) begin errors++; $display("FAIL reset_status got %08h want 00020010", got_rd); end
        rd_reg(2'd3);
        checks++; if (got_rd !== 32'h0) begin errors++; $display("FAIL reserved_read got %08h want 00000000", got_rd); end
        rd_reg(2'd0);
        checks++; if (got_rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL empty_rx_read got %08h want ffffffff", got_rd); end
        $display("test_reset done");
    endtask

    task automatic test_basic_tx();
        wr_reg(2'd0, 32'h41);
        checks++; if (uart_tx_valid !== 1'b1) begin errors++; $display("FAIL basic_tx_valid got %0b want 1", uart_tx_valid); end
        wr_reg(2'd0, 32'h42);
        idle(500);
        checks++; if (uart_tx_data !== 8'h41) begin errors++; $display("FAIL basic_tx_head got %02h want 41", uart_tx_data); end
        step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 8'h00);
        checks++; if (uart_tx_data !== 8'h42) begin errors++; $display("FAIL basic_tx_next got %02h want 42", uart_tx_data); end
        rd_reg(2'd1);
        checks++; if (got_rd !== 32'h0000_000F) begin errors++; $display("FAIL basic_tx_status1 got %08h want 0000000f", got_rd); end
        idle(500);
        step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 8'h00);
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL basic_tx_drained got %0b want 0", uart_tx_valid); end
        rd_reg(2'd1);
        checks++; if (got_rd !== 32'h0002_0010) begin errors++; $display("FAIL basic_tx_status2 got %08h want 00020010", got_rd); end
        $display("test_basic_tx done");
    endtask

    task automatic test_tx_full();
        for (int i = 0; i <= 16; i++) wr_reg(2'd0, 32'(i));
        rd_reg(2'd1);
        checks++; if (got_rd !== 32'h0000_0000) begin errors++; $display("FAIL tx_full_status got %08h want 00000000", got_rd); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'(i)) begin
                errors++; $display("FAIL tx_full_drain[%0d] got v=%0b %02h want v=1 %02h", i, uart_tx_valid, uart_tx_data, 8'(i));
            end
            step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 8'h00);
        end
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_full_empty got %0b want 0", uart_tx_valid); end
        $display("test_tx_full done");
    endtask

    task automatic test_rx_overflow();
        for (int i = 0; i <= 16; i++) step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 8'(8'h80 + i));
        rd_reg(2'd1);
        checks++; if (got_rd !== 32'h0003_1010) begin errors++; $display("FAIL rx_ovf_status got %08h want 00031010", got_rd); end
        for (int i = 0; i < 16; i++) begin
            rd_reg(2'd0);
            checks++; if (got_rd !== 32'(8'h80 + i)) begin errors++; $display("FAIL rx_ovf_read[%0d] got %08h want %08h", i, got_rd, 32'(8'h80 + i)); end
        end
        rd_reg(2'd0);
        checks++; if (got_rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rx_ovf_empty got %08h want ffffffff", got_rd); end
        rd_reg(2'd1);
        checks++; if (got_rd !== 32'h0003_0010) begin errors++; $display("FAIL rx_ovf_sticky got %08h want 00030010", got_rd); end
        wr_reg(2'd1, 32'h0001_0000);
        rd_reg(2'd1);
        checks++; if (got_rd !== 32'h0002_0010) begin errors++; $display("FAIL rx_ovf_clear got %08h want 00020010", got_rd); end
        $display("test_rx_overflow done");
    endtask

    task automatic test_simultaneous();
        // RX pop and push together on a full FIFO
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
        step(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 8'h55);
        checks++; if (got_rd !== exp_rd) begin errors++; $display("FAIL sim_rx_pop got %08h want %08h", got_rd, exp_rd); end
        rd_reg(2'd1);
        checks++; if (got_rd !== 32'h0002_1010) begin errors++; $display("FAIL sim_rx_status got %08h want 00021010", got_rd); end
        for (int i = 0; i < 16; i++) begin
            rd_reg(2'd0);
            checks++; if (got_rd !== exp_rd) begin errors++; $display("FAIL sim_rx_drain[%0d] got %08h want %08h", i, got_rd, exp_rd); end
        end
        checks++; if (got_rd !== 32'h55) begin errors++; $display("FAIL sim_rx_last got %08h want 00000055", got_rd); end
        // TX push and completion together on a full FIFO
        for (int i = 0; i < 16; i++) wr_reg(2'd0, 32'($urandom_range(0, 255)));
        step(1'b1, 1'b1, 2'd0, 32'hAA, 1'b1, 1'b0, 8'h00);
        rd_reg(2'd1);
        checks++; if (got_rd !== 32'h0000_0000) begin errors++; $display("FAIL sim_tx_status got %08h want 00000000", got_rd); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (uart_tx_data !== tx_q[0]) begin errors++; $display("FAIL sim_tx_drain[%0d] got %02h want %02h", i, uart_tx_data, tx_q[0]); end
            if (i == 15) begin
                checks++; if (uart_tx_data !== 8'hAA) begin errors++; $display("FAIL sim_tx_last got %02h want aa", uart_tx_data); end
            end
            step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 8'h00);
        end
        // Overflow set and software clear together: set wins
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 8'(i));
        step(1'b1, 1'b1, 2'd1, 32'h0001_0000, 1'b0, 1'b1, 8'hEE);
        rd_reg(2'd1);
        checks++; if (got_rd !== 32'h0003_1010) begin errors++; $display("FAIL sim_ovf_setwins got %08h want 00031010", got_rd); end
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) wr_reg(2'd0, 32'(8'hC0 + i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 8'(8'hD0 + i));
        // completes arriving in the reset cycle must be ignored
        reset            = 1'b1;
        uart_tx_complete = 1'b1;
        uart_rx_complete = 1'b1;
        uart_rx_data     = 8'h77;
        @(negedge clock);
        reset            = 1'b0;
        uart_tx_complete = 1'b0;
        uart_rx_complete = 1'b0;
        model_reset();
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid got %0b want 0", uart_tx_valid); end
        rd_reg(2'd1);
        checks++; if (got_rd !== 32'h0002_0010) begin errors++; $display("FAIL reset_mid_status got %08h want 00020010", got_rd); end
        rd_reg(2'd0);
        checks++; if (got_rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_mid_rx got %08h want ffffffff", got_rd); end
        $display("test_reset_mid done");
    endtask

    task automatic test_irq();
        wr_reg(2'd2, 32'h1);
        rd_reg(2'd2);
        checks++; if (got_rd !== exp_rd) begin errors++; $display("FAIL irq_ctrl_read got %08h want %08h", got_rd, exp_rd); end
        step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 8'h3C);
        idle(1);
`ifdef UART_CTRL_IRQ_EN
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got %0b want 1", irq); end
`else
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off got %0b want 0", irq); end
`endif
        rd_reg(2'd0);
        idle(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert got %0b want 0", irq); end
        wr_reg(2'd2, 32'h0);
        $display("test_irq done");
    endtask

    task automatic test_random();
        logic        req, wr, txc, rxc;
        logic [1:0]  addr;
        logic [31:0] wd;
        for (int n = 0; n < 800; n++) begin
            req  = ($urandom_range(0, 1) == 1);
            wr   = ($urandom_range(0, 1) == 1);
            addr = ($urandom_range(0, 3) < 2) ? 2'd0 : 2'($urandom_range(1, 3));
            wd   = $urandom;
            txc  = ($urandom_range(0, 5) == 0);
            rxc  = ($urandom_range(0, 2) == 0);
            step(req, wr, addr, wd, txc, rxc, 8'($urandom));
            checks++; if (got_ack !== req) begin errors++; $display("FAIL rand_ack[%0d] got %0b want %0b", n, got_ack, req); end
            if (req && !wr) begin
                checks++; if (got_rd !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d] addr=%0d got %08h want %08h", n, addr, got_rd, exp_rd); end
            end
            checks++; if (uart_tx_valid !== (tx_q.size() != 0)) begin errors++; $display("FAIL rand_tx_valid[%0d] got %0b want %0b", n, uart_tx_valid, tx_q.size() != 0); end
            if (tx_q.size() != 0) begin
                checks++; if (uart_tx_data !== tx_q[0]) begin errors++; $display("FAIL rand_tx_data[%0d] got %02h want %02h", n, uart_tx_data, tx_q[0]); end
            end
`ifndef UART_CTRL_IRQ_EN
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rand_irq[%0d] got %0b want 0", n, irq); end
`endif
        end
        $display("test_random done");
    endtask

    initial begin
        reset            = 1'b1;
        cpu_req          = 1'b0;
        cpu_write        = 1'b0;
        cpu_addr         = 2'd0;
        cpu_wdata        = '0;
        uart_tx_complete = 1'b0;
        uart_rx_complete = 1'b0;
        uart_rx_data     = '0;
        model_reset();
        @(negedge clock);
        test_reset();
        test_basic_tx();
        test_tx_full();
        test_rx_overflow();
        test_simultaneous();
        test_reset_mid();
        test_irq();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
